// File: rtl/xadc_drp_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared XADC DRP: one DRP access per accepted request.
// Latency: accept at T -> den at T+1 -> rsp at T+3 earliest, T+2+TIMEOUT_CYCLES on timeout.
// Backpressure: req_ready only in IDLE for the granted port; responses are single-cycle pulses with no backpressure.
module xadc_drp_arbiter #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  xadc_dclk,
    input  logic                  xadc_reset_n,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic                  m0_req_we,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_data,
    output logic                  m0_rsp_err,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic                  m1_req_we,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_data,
    output logic                  m1_rsp_err,

    output logic [ADDR_WIDTH-1:0] xadc_daddr,
    output logic                  xadc_den,
    output logic                  xadc_dwe,
    output logic [DATA_WIDTH-1:0] xadc_di,
    input  logic                  xadc_drdy,
    input  logic [DATA_WIDTH-1:0] xadc_do,

    output logic                  busy
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic            last_grant;
    logic            owner;
    logic [CW-1:0]   cnt;
    logic            grant;
    logic            grant_vld;
    logic            accept;
    logic            wait_done;
    logic [DATA_WIDTH-1:0] rsp_d;
    logic            rsp_e;

    // Tie goes to the port that did not win last time.
    always_comb begin
        grant_vld = m0_req_valid | m1_req_valid;
        grant     = (m0_req_valid && m1_req_valid) ? ~last_grant : m1_req_valid;
        accept    = (state == S_IDLE) && grant_vld;
        wait_done = xadc_drdy || (cnt == CNT_LAST);
        rsp_d     = (xadc_drdy && !xadc_dwe) ? xadc_do : '0;
        rsp_e     = !xadc_drdy;
    end

    assign m0_req_ready = accept && !grant;
    assign m1_req_ready = accept &&  grant;

    always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
        if (!xadc_reset_n) begin
            state        <= S_IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            cnt          <= '0;
            busy         <= 1'b0;
            xadc_den     <= 1'b0;
            xadc_dwe     <= 1'b0;
            xadc_daddr   <= '0;
            xadc_di      <= '0;
            m0_rsp_valid <= 1'b0;
            m0_rsp_data  <= '0;
            m0_rsp_err   <= 1'b0;
            m1_rsp_valid <= 1'b0;
            m1_rsp_data  <= '0;
            m1_rsp_err   <= 1'b0;
        end else begin
            xadc_den     <= 1'b0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner      <= grant;
                        last_grant <= grant;
                        xadc_daddr <= grant ? m1_req_addr  : m0_req_addr;
                        xadc_dwe   <= grant ? m1_req_we    : m0_req_we;
                        xadc_di    <= grant ? m1_req_wdata : m0_req_wdata;
                        xadc_den   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // drdy takes priority over a timeout landing in the same cycle.
                    if (wait_done) begin
                        if (owner) begin
                            m1_rsp_valid <= 1'b1;
                            m1_rsp_data  <= rsp_d;
                            m1_rsp_err   <= rsp_e;
                        end else begin
                            m0_rsp_valid <= 1'b1;
                            m0_rsp_data  <= rsp_d;
                            m0_rsp_err   <= rsp_e;
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Directed bench for xadc_drp_arbiter: vector table of single transactions plus
// hand-written contention, spurious-drdy and mid-WAIT reset sequences.
module tb_xadc_drp_arbiter;

    localparam int AW = 7;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          xadc_dclk = 1'b0;
    logic          xadc_reset_n;
    logic          m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_err;
    logic [AW-1:0] m0_req_addr;
    logic [DW-1:0] m0_req_wdata, m0_rsp_data;
    logic          m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_err;
    logic [AW-1:0] m1_req_addr;
    logic [DW-1:0] m1_req_wdata, m1_rsp_data;
    logic [AW-1:0] xadc_daddr;
    logic          xadc_den, xadc_dwe, xadc_drdy, busy;
    logic [DW-1:0] xadc_di, xadc_do;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 xadc_dclk = ~xadc_dclk;

    xadc_drp_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .xadc_dclk(xadc_dclk), .xadc_reset_n(xadc_reset_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_req_we(m0_req_we), .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid),
        .m0_rsp_data(m0_rsp_data), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_we(m1_req_we), .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid),
        .m1_rsp_data(m1_rsp_data), .m1_rsp_err(m1_rsp_err),
        .xadc_daddr(xadc_daddr), .xadc_den(xadc_den), .xadc_dwe(xadc_dwe), .xadc_di(xadc_di),
        .xadc_drdy(xadc_drdy), .xadc_do(xadc_do), .busy(busy)
    );

    typedef struct {
        bit        port;
        bit        we;
        logic [6:0]  addr;
        logic [15:0] wdata;
        int        dly;       // cycles after den that drdy is driven; 0 = never
        logic [15:0] dov;
        logic [15:0] exp_data;
        bit        exp_err;
        int        exp_k;     // cycles after den cycle at which rsp_valid is seen
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input bit port, input bit we, input logic [6:0] addr, input logic [15:0] wd);
        if (port) begin
            m1_req_valid = 1'b1; m1_req_we = we; m1_req_addr = addr; m1_req_wdata = wd;
        end else begin
            m0_req_valid = 1'b1; m0_req_we = we; m0_req_addr = addr; m0_req_wdata = wd;
        end
    endtask

    // Called just after a negedge with the request(s) already driven.
    task automatic run_txn(input string nm, input bit exp_port, input bit we, input logic [6:0] addr,
                           input logic [15:0] wd, input int dly, input logic [15:0] dov,
                           input logic [15:0] exp_data, input bit exp_err, input int exp_k, input bit hold);
        bit got = 0;
        bit extra_den = 0;
        bit other_rsp = 0;
        int k_rsp = 0;
        logic [15:0] r_data = '0;
        logic r_err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m0_req_ready || m1_req_ready) begin got = 1; break; end
            @(negedge xadc_dclk); #1;
        end
        chk({nm, "/ready"}, got, 1);
        if (!got) return;
        chk({nm, "/grant"}, {m0_req_ready, m1_req_ready}, exp_port ? 2'b01 : 2'b10);
        @(negedge xadc_dclk); #1;
        chk({nm, "/den"}, xadc_den, 1);
        chk({nm, "/dwe"}, xadc_dwe, we);
        chk({nm, "/daddr"}, xadc_daddr, addr);
        if (we) chk({nm, "/di"}, xadc_di, wd);
        chk({nm, "/busy"}, busy, 1);
        if (!hold) begin
            if (exp_port) m1_req_valid = 1'b0; else m0_req_valid = 1'b0;
        end
        for (int k = 1; k <= TO + 3; k++) begin
            @(negedge xadc_dclk); #1;
            if (xadc_den) extra_den = 1;
            if (exp_port ? m0_rsp_valid : m1_rsp_valid) other_rsp = 1;
            if (exp_port ? m1_rsp_valid : m0_rsp_valid) begin
                k_rsp  = k;
                r_data = exp_port ? m1_rsp_data : m0_rsp_data;
                r_err  = exp_port ? m1_rsp_err : m0_rsp_err;
                xadc_drdy = 1'b0;
                break;
            end
            xadc_drdy = (k == dly);
            xadc_do   = (k == dly) ? dov : 16'hDEAD;
        end
        xadc_drdy = 1'b0;
        chk({nm, "/rsp_latency"}, k_rsp, exp_k);
        chk({nm, "/rsp_data"}, r_data, exp_data);
        chk({nm, "/rsp_err"}, r_err, exp_err);
        chk({nm, "/extra_den"}, extra_den, 0);
        chk({nm, "/other_rsp"}, other_rsp, 0);
        @(negedge xadc_dclk); #1;
        chk({nm, "/rsp_pulse_end"}, exp_port ? m1_rsp_valid : m0_rsp_valid, 0);
        chk({nm, "/busy_idle"}, busy, 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "/den"}, xadc_den, 0);
        chk({nm, "/dwe"}, xadc_dwe, 0);
        chk({nm, "/daddr"}, xadc_daddr, 0);
        chk({nm, "/di"}, xadc_di, 0);
        chk({nm, "/ready"}, {m0_req_ready, m1_req_ready}, 0);
        chk({nm, "/rsp_valid"}, {m0_rsp_valid, m1_rsp_valid}, 0);
        chk({nm, "/rsp_data"}, {m0_rsp_data, m1_rsp_data}, 0);
        chk({nm, "/rsp_err"}, {m0_rsp_err, m1_rsp_err}, 0);
        chk({nm, "/busy"}, busy, 0);
    endtask

    task automatic no_rsp_for(input string nm, input int n);
        bit seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge xadc_dclk); #1;
            if (m0_rsp_valid || m1_rsp_valid || busy) seen = 1;
        end
        chk(nm, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // port we addr   wdata    dly dov      exp_data exp_err exp_k
        vecs[0] = '{0, 0, 7'h03, 16'h0000, 2, 16'hABC0, 16'hABC0, 0, 3};
        vecs[1] = '{1, 1, 7'h41, 16'h1234, 1, 16'hFFFF, 16'h0000, 0, 2};
        vecs[2] = '{0, 0, 7'h22, 16'h0000, 0, 16'h0000, 16'h0000, 1, TO + 1};
        vecs[3] = '{0, 0, 7'h10, 16'h0000, 1, 16'h5A5A, 16'h5A5A, 0, 2};
        vecs[4] = '{1, 0, 7'h7F, 16'h0000, TO, 16'hBEEF, 16'hBEEF, 0, TO + 1};
        vecs[5] = '{1, 1, 7'h33, 16'hCAFE, 0, 16'h0000, 16'h0000, 1, TO + 1};
        vecs[6] = '{0, 1, 7'h00, 16'hFFFF, 3, 16'h1111, 16'h0000, 0, 4};

        xadc_reset_n = 1'b0;
        m0_req_valid = 0; m0_req_we = 0; m0_req_addr = '0; m0_req_wdata = '0;
        m1_req_valid = 0; m1_req_we = 0; m1_req_addr = '0; m1_req_wdata = '0;
        xadc_drdy = 0; xadc_do = '0;

        repeat (3) @(negedge xadc_dclk);
        #1 chk_reset_vals("reset");
        @(negedge xadc_dclk); xadc_reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            @(negedge xadc_dclk);
            set_req(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            #1;
            run_txn($sformatf("vec%0d", v), vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                    vecs[v].dly, vecs[v].dov, vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_k, 0);
        end

        // Spurious drdy while idle must not produce a response.
        @(negedge xadc_dclk); xadc_drdy = 1'b1; xadc_do = 16'h7777;
        @(negedge xadc_dclk); xadc_drdy = 1'b0;
        no_rsp_for("spurious_drdy", 3);

        // Contention from reset release: strict alternation starting with port 0.
        xadc_reset_n = 1'b0;
        @(negedge xadc_dclk); xadc_reset_n = 1'b1;
        set_req(0, 0, 7'h05, 16'h0000);
        set_req(1, 1, 7'h06, 16'h0606);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                run_txn($sformatf("cont%0d", i), 0, 0, 7'h05, 16'h0000, 1, 16'h1000 + 16'(i),
                        16'h1000 + 16'(i), 0, 2, 1);
            else
                run_txn($sformatf("cont%0d", i), 1, 1, 7'h06, 16'h0606, 1, 16'h2000,
                        16'h0000, 0, 2, 1);
        end
        m0_req_valid = 0; m1_req_valid = 0;

        // Reset in WAIT after a port-0 grant; afterwards a tie must still go to port 0.
        @(negedge xadc_dclk);
        set_req(0, 1, 7'h2A, 16'h4242);
        #1;
        chk("rstwait/ready", m0_req_ready, 1);
        @(negedge xadc_dclk); m0_req_valid = 0;
        #1 chk("rstwait/den", xadc_den, 1);
        @(negedge xadc_dclk); #1;
        chk("rstwait/busy_wait", busy, 1);
        xadc_reset_n = 1'b0;
        #1 chk_reset_vals("rstwait_async");
        @(negedge xadc_dclk); xadc_reset_n = 1'b1;
        xadc_drdy = 1'b1; xadc_do = 16'h9999;
        @(negedge xadc_dclk); xadc_drdy = 1'b0;
        no_rsp_for("rstwait/late_drdy", 4);
        set_req(0, 0, 7'h01, 16'h0000);
        set_req(1, 0, 7'h02, 16'h0000);
        #1;
        run_txn("post_rst_tie0", 0, 0, 7'h01, 16'h0000, 2, 16'h0101, 16'h0101, 0, 3, 0);
        run_txn("post_rst_tie1", 1, 0, 7'h02, 16'h0000, 1, 16'h0202, 16'h0202, 0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
